// File: rtl/ovl_fire_collector.sv
// Collects {cover, xcheck, 2state} fire vectors from a bank of OVL checkers: saturating event
// counters, sticky fail mask, first-failure capture and irq/ack. Optional: OVL_FIRE_COLLECTOR_TSTAMP_EN.
module ovl_fire_collector #(
   parameter  int NUM_CHECKERS = 8,
   parameter  int CNT_W        = 16,
   parameter  int TS_W         = 32,
   localparam int ID_W         = (NUM_CHECKERS > 1) ? $clog2(NUM_CHECKERS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [3*NUM_CHECKERS-1:0] fire_bus,
   input  logic                      clear,
   input  logic                      ack,
   output logic                      irq,
   output logic                      first_valid,
   output logic [ID_W-1:0]           first_id,
   output logic [1:0]                first_type,
   output logic [NUM_CHECKERS-1:0]   fail_mask,
   output logic [CNT_W-1:0]          cnt_2state,
   output logic [CNT_W-1:0]          cnt_xcheck,
   output logic [CNT_W-1:0]          cnt_cover,
   output logic [TS_W-1:0]           first_tstamp
);

   localparam int PC_W  = $clog2(NUM_CHECKERS + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({CNT_W{1'b1}});

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURED = 2'd1,
      ST_ACKED    = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic                    irq_q, irq_d;
   logic                    first_valid_q, first_valid_d;
   logic [ID_W-1:0]         first_id_q, first_id_d;
   logic [1:0]              first_type_q, first_type_d;
   logic [NUM_CHECKERS-1:0] fail_mask_q, fail_mask_d;
   logic [CNT_W-1:0]        cnt_2state_q, cnt_2state_d;
   logic [CNT_W-1:0]        cnt_xcheck_q, cnt_xcheck_d;
   logic [CNT_W-1:0]        cnt_cover_q, cnt_cover_d;

   logic [NUM_CHECKERS-1:0] f2, fx, fc, fail_vec;
   logic [ID_W-1:0]         win_id;
   logic [1:0]              win_type;
   logic                    capture_go;

   function automatic logic [PC_W-1:0] popcount(input logic [NUM_CHECKERS-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_CHECKERS; i++) n = n + PC_W'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      return (s > SAT_MAX) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // Only a definite 1 counts as a fire, so an X on the bus never reaches the state.
   always_comb begin
      f2 = '0;
      fx = '0;
      fc = '0;
      for (int i = 0; i < NUM_CHECKERS; i++) begin
         f2[i] = (fire_bus[3*i]   === 1'b1);
         fx[i] = (fire_bus[3*i+1] === 1'b1);
         fc[i] = (fire_bus[3*i+2] === 1'b1);
      end
      fail_vec = f2 | fx;
   end

   // Scanning downwards leaves the lowest failing index as the winner.
   always_comb begin
      win_id   = '0;
      win_type = 2'b00;
      for (int i = NUM_CHECKERS - 1; i >= 0; i--) begin
         if (fail_vec[i]) begin
            win_id   = ID_W'(i);
            win_type = f2[i] ? 2'b01 : 2'b10;
         end
      end
   end

   assign capture_go = !clear && enable && (state_q == ST_IDLE) && (|fail_vec);

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      first_id_d   = first_id_q;
      first_type_d = first_type_q;
      fail_mask_d  = fail_mask_q;
      cnt_2state_d = cnt_2state_q;
      cnt_xcheck_d = cnt_xcheck_q;
      cnt_cover_d  = cnt_cover_q;

      if (clear) begin
         state_d      = ST_IDLE;
         first_id_d   = '0;
         first_type_d = 2'b00;
         fail_mask_d  = '0;
         cnt_2state_d = '0;
         cnt_xcheck_d = '0;
         cnt_cover_d  = '0;
      end else begin
         if (state_q == ST_CAPTURED && ack) state_d = ST_ACKED;
         if (enable) begin
            cnt_2state_d = sat_add(cnt_2state_q, popcount(f2));
            cnt_xcheck_d = sat_add(cnt_xcheck_q, popcount(fx));
            cnt_cover_d  = sat_add(cnt_cover_q, popcount(fc));
            fail_mask_d  = fail_mask_q | fail_vec;
         end
         if (capture_go) begin
            state_d      = ST_CAPTURED;
            first_id_d   = win_id;
            first_type_d = win_type;
         end
      end

      irq_d         = (state_d == ST_CAPTURED);
      first_valid_d = (state_d != ST_IDLE);
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         irq_q         <= 1'b0;
         first_valid_q <= 1'b0;
         first_id_q    <= '0;
         first_type_q  <= 2'b00;
         fail_mask_q   <= '0;
         cnt_2state_q  <= '0;
         cnt_xcheck_q  <= '0;
         cnt_cover_q   <= '0;
      end else begin
         state_q       <= state_d;
         irq_q         <= irq_d;
         first_valid_q <= first_valid_d;
         first_id_q    <= first_id_d;
         first_type_q  <= first_type_d;
         fail_mask_q   <= fail_mask_d;
         cnt_2state_q  <= cnt_2state_d;
         cnt_xcheck_q  <= cnt_xcheck_d;
         cnt_cover_q   <= cnt_cover_d;
      end
   end

`ifdef OVL_FIRE_COLLECTOR_TSTAMP_EN
   logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
   logic [TS_W-1:0] first_tstamp_q, first_tstamp_d;

   // The cycle counter free-runs, ignoring enable and clear; only reset zeroes it.
   always_comb begin
      ts_cnt_d       = ts_cnt_q + TS_W'(1);
      first_tstamp_d = first_tstamp_q;
      if (clear)           first_tstamp_d = '0;
      else if (capture_go) first_tstamp_d = ts_cnt_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ts_cnt_q       <= '0;
         first_tstamp_q <= '0;
      end else begin
         ts_cnt_q       <= ts_cnt_d;
         first_tstamp_q <= first_tstamp_d;
      end
   end

   assign first_tstamp = first_tstamp_q;
`else
   assign first_tstamp = '0;
`endif

   assign irq         = irq_q;
   assign first_valid = first_valid_q;
   assign first_id    = first_id_q;
   assign first_type  = first_type_q;
   assign fail_mask   = fail_mask_q;
   assign cnt_2state  = cnt_2state_q;
   assign cnt_xcheck  = cnt_xcheck_q;
   assign cnt_cover   = cnt_cover_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Scoreboard bench for ovl_fire_collector: a behavioural model predicts every cycle's outputs,
// which are queued at drive time and compared after the clock edge.
module tb_ovl_fire_collector;

   localparam int N  = 8;
   localparam int CW = 4;
   localparam int TW = 32;
   localparam int IW = 3;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic            clear = 1'b0;
   logic            ack = 1'b0;
   logic [3*N-1:0]  fire_bus = '0;
   logic            irq, first_valid;
   logic [IW-1:0]   first_id;
   logic [1:0]      first_type;
   logic [N-1:0]    fail_mask;
   logic [CW-1:0]   cnt_2state, cnt_xcheck, cnt_cover;
   logic [TW-1:0]   first_tstamp;

   ovl_fire_collector #(.NUM_CHECKERS(N), .CNT_W(CW), .TS_W(TW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .fire_bus(fire_bus),
      .clear(clear), .ack(ack), .irq(irq), .first_valid(first_valid),
      .first_id(first_id), .first_type(first_type), .fail_mask(fail_mask),
      .cnt_2state(cnt_2state), .cnt_xcheck(cnt_xcheck), .cnt_cover(cnt_cover),
      .first_tstamp(first_tstamp)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          irq;
      logic          valid;
      logic [IW-1:0] id;
      logic [1:0]    typ;
      logic [N-1:0]  mask;
      logic [CW-1:0] c2, cx, cc;
      logic [TW-1:0] ts;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   // Reference model state: 0 idle, 1 captured, 2 acked.
   int            m_st;
   logic [IW-1:0] m_id;
   logic [1:0]    m_typ;
   logic [N-1:0]  m_mask;
   int            m_c2, m_cx, m_cc;
   logic [TW-1:0] m_time, m_ts;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3*N-1:0] fb(input int id, input int kind);
      logic [3*N-1:0] v;
      v = '0;
      v[3*id+kind] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_st = 0; m_id = '0; m_typ = 2'b00; m_mask = '0;
      m_c2 = 0; m_cx = 0; m_cc = 0; m_time = '0; m_ts = '0;
   endtask

   task automatic model_edge(input logic en, input logic [3*N-1:0] bus,
                             input logic clr, input logic ak);
      int   max_cnt;
      int   p2, px, pc;
      logic found;
      max_cnt = (1 << CW) - 1;
      p2 = 0; px = 0; pc = 0; found = 1'b0;
      if (clr) begin
         m_st = 0; m_id = '0; m_typ = 2'b00; m_mask = '0;
         m_c2 = 0; m_cx = 0; m_cc = 0; m_ts = '0;
      end else begin
         if (m_st == 1 && ak) m_st = 2;
         if (en) begin
            for (int i = 0; i < N; i++) begin
               logic is2, isx;
               is2 = (bus[3*i] === 1'b1);
               isx = (bus[3*i+1] === 1'b1);
               if (is2) p2++;
               if (isx) px++;
               if (bus[3*i+2] === 1'b1) pc++;
               if (is2 || isx) begin
                  m_mask[i] = 1'b1;
                  if (m_st == 0 && !found) begin
                     found = 1'b1;
                     m_id  = IW'(i);
                     m_typ = is2 ? 2'b01 : 2'b10;
                  end
               end
            end
            m_c2 = (m_c2 + p2 > max_cnt) ? max_cnt : m_c2 + p2;
            m_cx = (m_cx + px > max_cnt) ? max_cnt : m_cx + px;
            m_cc = (m_cc + pc > max_cnt) ? max_cnt : m_cc + pc;
            if (found) begin
               m_st = 1;
`ifdef OVL_FIRE_COLLECTOR_TSTAMP_EN
               m_ts = m_time;
`endif
            end
         end
      end
      m_time = m_time + 1;
   endtask

   task automatic push_expected(input string tag);
      exp_t e;
      e.irq = (m_st == 1); e.valid = (m_st != 0); e.id = m_id; e.typ = m_typ;
      e.mask = m_mask; e.c2 = CW'(m_c2); e.cx = CW'(m_cx); e.cc = CW'(m_cc); e.ts = m_ts;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic compare_next();
      exp_t  e;
      string t;
      if (sb_q.size() == 0) begin
         check("scoreboard_underflow", 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         check({t, ".irq"},         64'(irq),          64'(e.irq));
         check({t, ".first_valid"}, 64'(first_valid),  64'(e.valid));
         check({t, ".first_id"},    64'(first_id),     64'(e.id));
         check({t, ".first_type"},  64'(first_type),   64'(e.typ));
         check({t, ".fail_mask"},   64'(fail_mask),    64'(e.mask));
         check({t, ".cnt_2state"},  64'(cnt_2state),   64'(e.c2));
         check({t, ".cnt_xcheck"},  64'(cnt_xcheck),   64'(e.cx));
         check({t, ".cnt_cover"},   64'(cnt_cover),    64'(e.cc));
         check({t, ".first_tstamp"}, 64'(first_tstamp), 64'(e.ts));
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input string tag, input logic en, input logic [3*N-1:0] bus,
                       input logic clr, input logic ak);
      enable = en; fire_bus = bus; clear = clr; ack = ak;
      model_edge(en, bus, clr, ak);
      push_expected(tag);
      @(posedge clock);
      #1;
      compare_next();
      @(negedge clock);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      enable = 1'b0; fire_bus = '0; clear = 1'b0; ack = 1'b0;
      model_reset();
      push_expected(tag);
      #1;
      compare_next();
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      logic [3*N-1:0] all_cov, all_2s, xbus;
      all_cov = '0;
      all_2s  = '0;
      for (int i = 0; i < N; i++) begin
         all_cov = all_cov | fb(i, 2);
         all_2s  = all_2s  | fb(i, 0);
      end

      do_reset("reset0");
      step("idle", 1, '0, 0, 0);
      step("c5_2state", 1, fb(5, 0), 0, 0);
      step("c5_hold", 1, '0, 0, 0);

      do_reset("reset1");
      step("c3x_c6_2s", 1, fb(3, 1) | fb(6, 0), 0, 0);
      step("ack", 1, '0, 0, 1);
      step("c0_after_ack", 1, fb(0, 0), 0, 0);
      step("ack_in_acked", 1, fb(7, 1), 0, 1);

      do_reset("reset2");
      step("all_cover_1", 1, all_cov, 0, 0);
      step("all_cover_2", 1, all_cov, 0, 0);
      step("all_cover_3", 1, all_cov, 0, 0);
      step("all_2s_1", 1, all_2s, 0, 0);
      step("all_2s_2", 1, all_2s, 0, 0);

      do_reset("reset3");
      step("c4_capture", 1, fb(4, 0), 0, 0);
      step("clear_with_c2", 1, fb(2, 0), 1, 0);
      step("disabled_fires", 0, fb(1, 0) | fb(3, 1) | fb(5, 2), 0, 0);
      step("c1x_capture", 1, fb(1, 1), 0, 0);
      step("disabled_ack", 0, fb(0, 0), 0, 1);
      step("c2_recapture_blocked", 1, fb(2, 0), 0, 0);
      step("clear_alone", 1, '0, 1, 0);
      step("c6_capture", 1, fb(6, 0), 0, 0);
      step("ack_and_clear", 1, '0, 1, 1);
      step("ack_in_idle", 1, '0, 0, 1);
      step("c7_capture", 1, fb(7, 1) | fb(7, 0), 0, 0);
      #2;
      do_reset("async_reset_mid_captured");

      xbus = fb(1, 2);
      xbus[3*7+1] = 1'bx;
      xbus[3*4]   = 1'bx;
      step("x_on_bus", 1, xbus, 0, 0);

      do_reset("reset4");
      for (int i = 0; i < 10; i++) step("ts_idle", 1, '0, 0, 0);
      step("ts_capture", 1, fb(2, 1), 0, 0);
      step("ts_hold", 1, fb(0, 0), 0, 0);

      do_reset("reset5");
      for (int i = 0; i < 60; i++) begin
         logic [3*N-1:0] rb;
         rb = '0;
         for (int j = 0; j < 3*N; j++) rb[j] = ($urandom_range(0, 7) == 0);
         step("random", ($urandom_range(0, 3) != 0), rb,
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
